la_capture_buf: RTL and testbench

LA_CAPTURE_BUF -- requirements
Module: la_capture_buf

---
 rtl/la_pkg.sv | 20 ++
 rtl/la_sdp_ram.sv | 18 +
 rtl/la_capture_buf.sv | 104 ++++++++++
 tb/tb_la_capture_buf.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// la_pkg: shared state encoding, trigger-mode encodings and per-channel hit helper for the logic analyser.
package la_pkg;
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4,
      ST_READ = 3'd5
   } la_state_e;
   localparam logic [1:0] TM_HIGH = 2'b00;
   localparam logic [1:0] TM_LOW  = 2'b01;
   localparam logic [1:0] TM_RISE = 2'b10;
   localparam logic [1:0] TM_FALL = 2'b11;
   function automatic logic trig_hit(input logic [1:0] mode, input logic cur, input logic prev);
      return mode == TM_HIGH ? cur :
             mode == TM_LOW  ? !cur :
             mode == TM_RISE ? cur && !prev : !cur && prev;
   endfunction
endpackage

// File: rtl/la_sdp_ram.sv
// la_sdp_ram: simple dual-port buffer with one write port and a registered (one-cycle) read port.
module la_sdp_ram #(
   parameter int DATA_W = 39,
   parameter int DEPTH  = 256
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/la_capture_buf.sv
// la_capture_buf: triggered capture buffer with pre-trigger history and ready/valid readout, oldest sample first.
module la_capture_buf import la_pkg::*; #(
   parameter int DATA_W   = 39,
   parameter int DEPTH    = 256,
   parameter int TRIG_W   = 4,
   parameter int PRE_TRIG = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_W-1:0]     data_i,
   input  logic [TRIG_W-1:0]     trig_i,
   input  logic [TRIG_W-1:0]     trig_en_i,
   input  logic [2*TRIG_W-1:0]   trig_mode_i,
   input  logic                  arm_i,
   input  logic                  abort_i,
   input  logic                  rd_ready_i,
   output logic                  rd_valid_o,
   output logic [DATA_W-1:0]     rd_data_o,
   output logic                  rd_last_o,
   output logic [2:0]            state_o,
   output logic                  done_o
);
   localparam int AW     = $clog2(DEPTH);
   localparam int POST_N = DEPTH - PRE_TRIG;
   la_state_e         state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
   logic [TRIG_W-1:0] trig_q, hit;
   logic              trigger, we, start;
   logic [DATA_W-1:0] ram_rdata;
   for (genvar c = 0; c < TRIG_W; c++) begin : g_hit
      assign hit[c] = !trig_en_i[c] || trig_hit(trig_mode_i[2*c +: 2], trig_i[c], trig_q[c]);
   end
   assign trigger = &hit;
   assign we      = state_q inside {ST_PRE, ST_WAIT, ST_POST};
   assign start   = arm_i && (state_q == ST_IDLE || state_q == ST_DONE);
   // cnt_q counts pre samples, then post samples, then transferred words
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
      cnt_d      = we ? cnt_q + 1'b1 : cnt_q;
      trig_ptr_d = trig_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      case (state_q)
         ST_PRE: if (cnt_q == AW'(PRE_TRIG - 1)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: if (trigger) begin
            state_d    = POST_N == 1 ? ST_DONE : ST_POST;
            trig_ptr_d = wr_ptr_q;
            cnt_d      = AW'(1);
         end
         ST_POST: if (cnt_q == AW'(POST_N - 1)) state_d = ST_DONE;
         ST_DONE: if (rd_ready_i) begin
            state_d  = ST_READ;
            rd_ptr_d = trig_ptr_q - AW'(PRE_TRIG);
            cnt_d    = '0;
         end
         ST_READ: if (rd_ready_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d  = PRE_TRIG == 0 ? ST_WAIT : ST_PRE;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end
      if (abort_i) state_d = ST_IDLE;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         trig_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         trig_ptr_q <= trig_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         trig_q     <= trig_i;
      end
   end
   // reading at the next pointer keeps ram_rdata equal to mem[rd_ptr_q], so stalls hold and transfers stream
   la_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk_i  (clk_i),
      .we_i   (we),
      .waddr_i(wr_ptr_q),
      .wdata_i(data_i),
      .raddr_i(rd_ptr_d),
      .rdata_o(ram_rdata)
   );
   assign rd_valid_o = state_q == ST_READ;
   assign rd_last_o  = rd_valid_o && cnt_q == AW'(DEPTH - 1);
   assign rd_data_o  = rd_valid_o ? ram_rdata : '0;
   assign state_o    = state_q;
   assign done_o     = state_q == ST_DONE;
endmodule

// File: tb/tb_la_capture_buf.sv
// tb_la_capture_buf: scoreboard bench for la_capture_buf with an 8-bit, 16-deep, 4-pre-trigger configuration.
module tb_la_capture_buf;
   localparam int DW = 8, D = 16, PT = 4, TW = 4;
   logic clk = 0, rst_n = 0;
   logic [DW-1:0] data = '0;
   logic [TW-1:0] trig = '0, en = '0;
   logic [2*TW-1:0] mode = '0;
   logic arm = 0, abort = 0, rdy = 0;
   logic rd_valid, rd_last, done;
   logic [DW-1:0] rd_data;
   logic [2:0] state;
   int n_tests = 0, n_fail = 0;
   int exp_q[$];
   int s;
   la_capture_buf #(.DATA_W(DW), .DEPTH(D), .TRIG_W(TW), .PRE_TRIG(PT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data_i(data), .trig_i(trig), .trig_en_i(en),
      .trig_mode_i(mode), .arm_i(arm), .abort_i(abort), .rd_ready_i(rdy),
      .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_last_o(rd_last),
      .state_o(state), .done_o(done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [TW-1:0] trig_fn(input int tc, input int k);
      logic [TW-1:0] t = '0;
      if (tc == 1) t[0] = (k == 2) || (k >= 10);
      if (tc == 3) begin
         t[0] = k >= 7;
         t[1] = k >= 9;
      end
      return t;
   endfunction
   task automatic push_exp(input int trig_at);
      for (int k = trig_at - PT; k < trig_at - PT + D; k++) exp_q.push_back(k);
   endtask
   task automatic start(input logic [TW-1:0] e, input logic [2*TW-1:0] m);
      en = e;
      mode = m;
      arm = 1;
      tick;
      arm = 0;
   endtask
   task automatic feed(input int tc, input int upto, input bit stop_done, output int s_end);
      int k = 0;
      while (k < upto) begin
         data = DW'(k);
         trig = trig_fn(tc, k);
         arm = (tc == 1 && k == 6);
         tick;
         if (tc == 1 && k == 6) check("arm_ignored_in_wait", state, 2);
         arm = 0;
         k++;
         if (stop_done && done) break;
      end
      trig = '0;
      s_end = k;
   endtask
   task automatic capture(input int tc, input logic [TW-1:0] e, input logic [2*TW-1:0] m, input int trig_at);
      push_exp(trig_at);
      start(e, m);
      feed(tc, 60, 1, s);
      check("done", done, 1);
      check("capture_len", s, trig_at + D - PT);
   endtask
   task automatic readout(input bit toggle, input int abort_after);
      int cyc = 0, got = 0, e;
      logic [DW-1:0] hd;
      logic hl;
      while (exp_q.size() > 0 && cyc < 80) begin
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         if (abort_after >= 0 && got == abort_after) begin
            abort = 1;
            tick;
            abort = 0;
            rdy = 0;
            check("abort_rd_state", state, 0);
            check("abort_rd_valid", rd_valid, 0);
            check("abort_rd_done", done, 0);
            exp_q.delete();
            return;
         end
         if (rd_valid && rdy) begin
            e = exp_q.pop_front();
            check("rd_data", rd_data, e);
            check("rd_last", rd_last, exp_q.size() == 0);
            got++;
            tick;
         end else if (rd_valid) begin
            hd = rd_data;
            hl = rd_last;
            tick;
            check("hold_valid", rd_valid, 1);
            check("hold_data", rd_data, hd);
            check("hold_last", rd_last, hl);
         end else tick;
         cyc++;
      end
      rdy = 0;
      check("rd_count", got, D);
      check("end_state", state, 0);
      check("end_valid", rd_valid, 0);
   endtask
   initial begin
      tick;
      check("rst_state", state, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_last", rd_last, 0);
      check("rst_data", rd_data, 0);
      check("rst_done", done, 0);
      rst_n = 1;
      tick;
      capture(1, 4'b0001, 8'b0000_0010, 10);
      readout(0, -1);
      capture(2, 4'b0000, 8'b0, 4);
      readout(0, -1);
      capture(3, 4'b0011, 8'b0, 9);
      readout(0, -1);
      capture(2, 4'b0000, 8'b0, 4);
      readout(1, -1);
      start(4'b0001, 8'b0000_0010);
      feed(0, 6, 0, s);
      check("in_wait", state, 2);
      abort = 1;
      tick;
      abort = 0;
      check("abort_wait_state", state, 0);
      check("abort_wait_valid", rd_valid, 0);
      check("abort_wait_done", done, 0);
      capture(2, 4'b0000, 8'b0, 4);
      readout(0, -1);
      capture(2, 4'b0000, 8'b0, 4);
      readout(0, 5);
      capture(3, 4'b0011, 8'b0, 9);
      readout(1, -1);
      start(4'b0000, 8'b0);
      feed(2, 10, 0, s);
      check("in_post", state, 3);
      rst_n = 0;
      #1;
      check("rst_post_state", state, 0);
      check("rst_post_valid", rd_valid, 0);
      check("rst_post_last", rd_last, 0);
      check("rst_post_data", rd_data, 0);
      check("rst_post_done", done, 0);
      tick;
      rst_n = 1;
      rdy = 1;
      tick;
      tick;
      check("post_rst_state", state, 0);
      check("post_rst_valid", rd_valid, 0);
      rdy = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
